// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and limits for the unified-memory arbiter
package mem_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_t;
  typedef enum logic [1:0] {OWN_IF, OWN_LS, OWN_LD} arb_owner_t;
  localparam int MAX_LAT = 16;
  typedef struct packed {
    logic       vld;
    logic       st;
    arb_owner_t own;
  } arb_resp_t;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: one-hot grant, loader > LS > IF, IF promoted when starvation is reached
module mem_arb_pick import mem_arb_pkg::*; (
  input  logic       en,
  input  logic       if_req,
  input  logic       ls_req,
  input  logic       ld_req,
  input  logic       force_if,
  output logic [2:0] gnt
);
  // loader always first; IF only beats LS when it has been starved long enough
  always_comb begin
    gnt = '0;
    gnt[OWN_LD] = en & ld_req;
    gnt[OWN_IF] = en & ~ld_req & if_req & (force_if | ~ls_req);
    gnt[OWN_LS] = en & ~ld_req & ls_req & ~force_if;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and load/store; ARB_LOADER_PORT_EN adds a loader write port and cpu_hold
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
`ifdef ARB_LOADER_PORT_EN
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              cpu_hold,
`endif
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int LW = $clog2(MAX_LAT) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  arb_state_t state, state_n;
  logic [LW-1:0] lat_cnt, lat_n;
  logic [SW-1:0] starve_cnt;
  logic [2:0] gnt;
  arb_resp_t pipe [MEM_LAT];
  arb_resp_t head, resp_in;
  logic ld_r;
  logic [ADDR_W-1:0] ld_a;
  logic [DATA_W-1:0] ld_d;
`ifdef ARB_LOADER_PORT_EN
  assign ld_r   = ld_req;
  assign ld_a   = ld_addr;
  assign ld_d   = ld_wdata;
  assign ld_gnt = gnt[OWN_LD];
  // hold the CPU off while the loader is requesting
  always_ff @(posedge clk or posedge rst)
    if (rst) cpu_hold <= 1'b1;
    else cpu_hold <= ld_req;
`else
  assign ld_r = 1'b0;
  assign ld_a = '0;
  assign ld_d = '0;
`endif
  mem_arb_pick u_pick (
    .en(state == ARB_IDLE && !rst),
    .if_req(if_req),
    .ls_req(ls_req),
    .ld_req(ld_r),
    .force_if(if_req && starve_cnt == SW'(STARVE_LIMIT)),
    .gnt(gnt)
  );
  assign if_gnt    = gnt[OWN_IF];
  assign ls_gnt    = gnt[OWN_LS];
  assign mem_en    = |gnt;
  assign mem_we    = gnt[OWN_LD] | (gnt[OWN_LS] & ls_we);
  assign mem_addr  = gnt[OWN_LD] ? ld_a : gnt[OWN_LS] ? ls_addr : gnt[OWN_IF] ? if_addr : '0;
  assign mem_wdata = gnt[OWN_LD] ? ld_d : (gnt[OWN_LS] & ls_we) ? ls_wdata : '0;
  assign resp_in   = '{vld: gnt[OWN_IF] | gnt[OWN_LS], st: gnt[OWN_LS] & ls_we, own: gnt[OWN_LS] ? OWN_LS : OWN_IF};
  assign head      = pipe[MEM_LAT-1];
  assign if_rvalid = head.vld && head.own == OWN_IF;
  assign ls_rvalid = head.vld && head.own == OWN_LS;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign ls_rdata  = (ls_rvalid && !head.st) ? mem_rdata : '0;
  // carry each access's owner MEM_LAT cycles so the read data is steered back to it
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < MEM_LAT; i++) pipe[i] <= '0;
    else begin
      pipe[0] <= resp_in;
      for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
    end
  // state and latency counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= ARB_IDLE;
      lat_cnt <= '0;
    end else begin
      state   <= state_n;
      lat_cnt <= lat_n;
    end
  // block further grants until a multi-cycle access has completed
  always_comb begin
    state_n = state;
    lat_n   = lat_cnt;
    if (state == ARB_IDLE) begin
      if (mem_en && MEM_LAT > 1) begin
        state_n = ARB_WAIT;
        lat_n   = LW'(MEM_LAT - 1);
      end
    end else begin
      lat_n = lat_cnt - 1'b1;
      if (lat_cnt == LW'(1)) state_n = ARB_IDLE;
    end
  end
  // count LS wins while IF waits; an IF win or an idle IF clears it
  always_ff @(posedge clk or posedge rst)
    if (rst) starve_cnt <= '0;
    else if (!if_req || gnt[OWN_IF]) starve_cnt <= '0;
    else if (gnt[OWN_LS] && starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a behavioural model
module tb_mem_arbiter;
  localparam int SL = 4;
  localparam int LB = 3;
  typedef struct {
    int          due;
    logic        ls;
    logic [31:0] data;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int vectors = 0;
  int errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask
  function automatic logic [31:0] init_word(input int i);
    return 32'hA5C30000 + 32'(i) * 32'h111;
  endfunction
  logic a_if_req = 0, a_ls_req = 0, a_ls_we = 0;
  logic [31:0] a_if_addr = 0, a_ls_addr = 0, a_ls_wdata = 0, a_mem_rdata = 0;
  logic a_if_gnt, a_if_rvalid, a_ls_gnt, a_ls_rvalid, a_mem_en, a_mem_we;
  logic [31:0] a_if_rdata, a_ls_rdata, a_mem_addr, a_mem_wdata;
  logic b_if_req = 0, b_ls_req = 0, b_ls_we = 0;
  logic [31:0] b_if_addr = 0, b_ls_addr = 0, b_ls_wdata = 0, b_mem_rdata;
  logic b_if_gnt, b_if_rvalid, b_ls_gnt, b_ls_rvalid, b_mem_en, b_mem_we;
  logic [31:0] b_if_rdata, b_ls_rdata, b_mem_addr, b_mem_wdata;
`ifdef ARB_LOADER_PORT_EN
  logic a_ld_req = 0, b_ld_req = 0;
  logic [31:0] a_ld_addr = 0, a_ld_wdata = 0, b_ld_addr = 0, b_ld_wdata = 0;
  logic a_ld_gnt, a_cpu_hold, b_ld_gnt, b_cpu_hold;
`endif
  mem_arbiter #(.MEM_LAT(1), .STARVE_LIMIT(SL)) u_a (
    .clk(clk), .rst(rst),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt), .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
    .ls_req(a_ls_req), .ls_we(a_ls_we), .ls_addr(a_ls_addr), .ls_wdata(a_ls_wdata),
    .ls_gnt(a_ls_gnt), .ls_rvalid(a_ls_rvalid), .ls_rdata(a_ls_rdata),
`ifdef ARB_LOADER_PORT_EN
    .ld_req(a_ld_req), .ld_addr(a_ld_addr), .ld_wdata(a_ld_wdata), .ld_gnt(a_ld_gnt), .cpu_hold(a_cpu_hold),
`endif
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );
  mem_arbiter #(.MEM_LAT(LB), .STARVE_LIMIT(SL)) u_b (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .ls_req(b_ls_req), .ls_we(b_ls_we), .ls_addr(b_ls_addr), .ls_wdata(b_ls_wdata),
    .ls_gnt(b_ls_gnt), .ls_rvalid(b_ls_rvalid), .ls_rdata(b_ls_rdata),
`ifdef ARB_LOADER_PORT_EN
    .ld_req(b_ld_req), .ld_addr(b_ld_addr), .ld_wdata(b_ld_wdata), .ld_gnt(b_ld_gnt), .cpu_hold(b_cpu_hold),
`endif
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );
  logic [31:0] bmem [16];
  logic [31:0] bpipe [LB];
  always @(posedge clk) begin
    if (rst) for (int i = 0; i < 16; i++) bmem[i] <= init_word(i);
    else if (b_mem_en && b_mem_we) bmem[b_mem_addr[5:2]] <= b_mem_wdata;
    bpipe[0] <= (b_mem_en && !b_mem_we) ? bmem[b_mem_addr[5:2]] : $urandom;
    for (int i = 1; i < LB; i++) bpipe[i] <= bpipe[i-1];
  end
  assign b_mem_rdata = bpipe[LB-1];
  logic [31:0] refmem [16];
  exp_t q[$];
  exp_t e;
  int busy, starve;
  logic g_if, g_ls, hit;
  logic [3:0] idx;
  initial begin
    for (int i = 0; i < 16; i++) refmem[i] = init_word(i);
    a_if_req = 1;
    a_ls_req = 1;
    b_if_req = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst a_if_gnt", a_if_gnt, 0);
    check("rst a_ls_gnt", a_ls_gnt, 0);
    check("rst a_mem_en", a_mem_en, 0);
    check("rst a_mem_we", a_mem_we, 0);
    check("rst a_if_rvalid", a_if_rvalid, 0);
    check("rst a_ls_rvalid", a_ls_rvalid, 0);
    check("rst a_ls_rdata", a_ls_rdata, 0);
    check("rst b_mem_en", b_mem_en, 0);
`ifdef ARB_LOADER_PORT_EN
    check("rst cpu_hold", a_cpu_hold, 1);
    check("rst ld_gnt", a_ld_gnt, 0);
`endif
    @(posedge clk); #1;
    rst = 0;
    a_if_req = 0;
    a_ls_req = 0;
    b_if_req = 0;
    // single fetch, one-cycle memory
    @(posedge clk); #1;
    a_if_req = 1;
    a_if_addr = 32'h0;
    a_mem_rdata = 32'h00500093;
    @(negedge clk);
    check("fetch gnt", a_if_gnt, 1);
    check("fetch en", a_mem_en, 1);
    check("fetch addr", a_mem_addr, 0);
    check("fetch early rvalid", a_if_rvalid, 0);
    @(posedge clk); #1;
    a_if_req = 0;
    @(negedge clk);
    check("fetch rvalid", a_if_rvalid, 1);
    check("fetch rdata", a_if_rdata, 32'h00500093);
    check("idle en", a_mem_en, 0);
    check("idle addr", a_mem_addr, 0);
    // store and fetch together: LS first
    @(posedge clk); #1;
    a_if_req = 1;
    a_if_addr = 32'h4;
    a_ls_req = 1;
    a_ls_we = 1;
    a_ls_addr = 32'h100;
    a_ls_wdata = 32'hDEADBEEF;
    @(negedge clk);
    check("st ls_gnt", a_ls_gnt, 1);
    check("st if_gnt", a_if_gnt, 0);
    check("st mem_we", a_mem_we, 1);
    check("st mem_addr", a_mem_addr, 32'h100);
    check("st mem_wdata", a_mem_wdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    a_ls_req = 0;
    a_ls_we = 0;
    @(negedge clk);
    check("st2 if_gnt", a_if_gnt, 1);
    check("st2 mem_addr", a_mem_addr, 32'h4);
    check("st2 mem_we", a_mem_we, 0);
    check("st ack", a_ls_rvalid, 1);
    check("st ack rdata", a_ls_rdata, 0);
    @(posedge clk); #1;
    a_if_req = 0;
    @(negedge clk);
    check("st3 if_rvalid", a_if_rvalid, 1);
    check("st3 ls_rvalid", a_ls_rvalid, 0);
    // starvation: 4 LS grants, then IF, then LS again
    @(posedge clk); #1;
    a_if_req = 1;
    a_if_addr = 32'h8;
    a_ls_req = 1;
    a_ls_addr = 32'h200;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("starve%0d ls_gnt", k), a_ls_gnt, k != 4);
      check($sformatf("starve%0d if_gnt", k), a_if_gnt, k == 4);
      @(posedge clk); #1;
    end
    a_if_req = 0;
    a_ls_req = 0;
`ifdef ARB_LOADER_PORT_EN
    @(posedge clk); #1;
    a_ld_req = 1;
    a_ld_addr = 32'h40;
    a_ld_wdata = 32'h12345678;
    a_if_req = 1;
    a_ls_req = 1;
    @(negedge clk);
    check("ld gnt", a_ld_gnt, 1);
    check("ld if_gnt", a_if_gnt, 0);
    check("ld ls_gnt", a_ls_gnt, 0);
    check("ld mem_we", a_mem_we, 1);
    check("ld mem_addr", a_mem_addr, 32'h40);
    check("ld mem_wdata", a_mem_wdata, 32'h12345678);
    @(posedge clk); #1;
    a_ld_req = 0;
    @(negedge clk);
    check("ld cpu_hold", a_cpu_hold, 1);
    check("ld no if_rvalid", a_if_rvalid, 0);
    check("ld no ls_rvalid", a_ls_rvalid, 0);
    check("ld then ls_gnt", a_ls_gnt, 1);
    @(posedge clk); #1;
    a_if_req = 0;
    a_ls_req = 0;
    @(negedge clk);
    check("ld cpu_hold off", a_cpu_hold, 0);
`endif
    // three-cycle memory, back-to-back fetches
    @(posedge clk); #1;
    b_if_req = 1;
    b_if_addr = 32'h0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("b2b%0d gnt", k), b_if_gnt, (k % 3 == 0) && k <= 6);
      check($sformatf("b2b%0d rvalid", k), b_if_rvalid, (k % 3 == 0) && k >= 3);
      if ((k % 3 == 0) && k >= 3) check($sformatf("b2b%0d rdata", k), b_if_rdata, init_word(k / 3 - 1));
      @(posedge clk); #1;
      if (k % 3 == 0) b_if_addr = 32'((k / 3 + 1) * 4);
      if (k == 6) b_if_req = 0;
    end
    // reset in the middle of a wait
    b_if_req = 1;
    b_if_addr = 32'h10;
    @(negedge clk);
    check("rw gnt", b_if_gnt, 1);
    @(posedge clk); #1;
    #1 rst = 1;
    #1;
    check("rw rst gnt", b_if_gnt, 0);
    check("rw rst en", b_mem_en, 0);
    check("rw rst rvalid", b_if_rvalid, 0);
    @(posedge clk); #1;
    rst = 0;
    b_if_req = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("rw late rvalid%0d", k), b_if_rvalid, 0);
      @(posedge clk); #1;
    end
    b_if_req = 1;
    @(negedge clk);
    check("rw idle after rst", b_if_gnt, 1);
    @(posedge clk); #1;
    b_if_req = 0;
    repeat (5) @(posedge clk);
    #1;
    // randomized traffic against the model
    busy = 0;
    starve = 0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      g_if = busy == 0 && b_if_req && (!b_ls_req || starve == SL);
      g_ls = busy == 0 && b_ls_req && !g_if;
      check("rnd if_gnt", b_if_gnt, g_if);
      check("rnd ls_gnt", b_ls_gnt, g_ls);
      check("rnd mem_en", b_mem_en, g_if | g_ls);
      check("rnd mem_we", b_mem_we, g_ls && b_ls_we);
      check("rnd mem_addr", b_mem_addr, g_ls ? b_ls_addr : g_if ? b_if_addr : 32'h0);
      if (g_ls && b_ls_we) check("rnd mem_wdata", b_mem_wdata, b_ls_wdata);
      hit = 0;
      if (q.size() != 0) if (q[0].due == n) begin
        e = q.pop_front();
        hit = 1;
      end
      check("rnd if_rvalid", b_if_rvalid, hit && !e.ls);
      check("rnd ls_rvalid", b_ls_rvalid, hit && e.ls);
      if (hit) check(e.ls ? "rnd ls_rdata" : "rnd if_rdata", e.ls ? b_ls_rdata : b_if_rdata, e.data);
      if (g_if || g_ls) begin
        idx = g_ls ? b_ls_addr[5:2] : b_if_addr[5:2];
        if (g_ls && b_ls_we) begin
          refmem[idx] = b_ls_wdata;
          q.push_back('{n + LB, 1'b1, 32'h0});
        end else q.push_back('{n + LB, g_ls, refmem[idx]});
        busy = LB;
      end
      starve = (!b_if_req || g_if) ? 0 : (g_ls && starve < SL) ? starve + 1 : starve;
      if (busy > 0) busy--;
      @(posedge clk); #1;
      if (!b_if_req || g_if) begin
        b_if_req = $urandom_range(0, 3) != 0;
        b_if_addr = 32'($urandom_range(0, 15)) << 2;
      end else if ($urandom_range(0, 15) == 0) b_if_req = 0;
      if (!b_ls_req || g_ls) begin
        b_ls_req = $urandom_range(0, 3) != 0;
        b_ls_we = 1'($urandom_range(0, 1));
        b_ls_addr = 32'($urandom_range(0, 15)) << 2;
        b_ls_wdata = $urandom;
      end else if ($urandom_range(0, 15) == 0) b_ls_req = 0;
    end
    b_if_req = 0;
    b_ls_req = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
